// File: rtl/rx_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer: command codes,
// ALU operand register addresses and the FSM state encoding.
package rx_cmd_sequencer_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_A    = 4'd5,
    ST_ALU_B    = 4'd6,
    ST_ALU_FN   = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LO    = 4'd9,
    ST_TX_HI    = 4'd10
  } state_e;

endpackage

// File: rtl/rx_cmd_wait_timer.sv
// Loadable down-counter bounding how long the sequencer waits for a
// read-data or ALU-result pulse; expired is high on the last allowed cycle.
module rx_cmd_wait_timer #(
  parameter int TIMEOUT = 31
) (
  input  logic CLK,
  input  logic RST,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic          run_q;

  // Loading TIMEOUT-1 gives exactly TIMEOUT waiting cycles before expiry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= CW'(TIMEOUT - 1);
      run_q <= 1'b1;
    end else if (clear_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (run_q && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/rx_cmd_sequencer.sv
// Decodes UART RX bytes into write/read/ALU command frames, drives the
// register file and ALU, and pushes response bytes into the TX FIFO.
module rx_cmd_sequencer
  import rx_cmd_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    cmd_err
);

  localparam logic [DATA_WIDTH-1:0] C_WR      = DATA_WIDTH'(CMD_WR);
  localparam logic [DATA_WIDTH-1:0] C_RD      = DATA_WIDTH'(CMD_RD);
  localparam logic [DATA_WIDTH-1:0] C_ALU_OP  = DATA_WIDTH'(CMD_ALU_OP);
  localparam logic [DATA_WIDTH-1:0] C_ALU_NOP = DATA_WIDTH'(CMD_ALU_NOP);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_buf_q;
  logic [2*DATA_WIDTH-1:0] result_q;
  logic                    two_byte_q;

  logic [ADDR_WIDTH-1:0]   address_q;
  logic                    wr_en_q;
  logic                    rd_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    alu_en_q;
  logic [FUN_WIDTH-1:0]    alu_fun_q;
  logic                    clk_en_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_vld_q;
  logic                    cmd_err_q;

  logic timer_start;
  logic timer_clear;
  logic timer_expired;

  assign timer_start = RX_D_VLD && ((state_q == ST_RD_ADDR) || (state_q == ST_ALU_FN));
  assign timer_clear = (state_q != ST_RD_WAIT) && (state_q != ST_ALU_WAIT);

  rx_cmd_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK       (CLK),
    .RST       (RST),
    .start_i   (timer_start),
    .clear_i   (timer_clear),
    .expired_o (timer_expired)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      addr_buf_q <= '0;
      result_q   <= '0;
      two_byte_q <= 1'b0;
      address_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_data_q  <= '0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      clk_en_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              C_WR:      state_q <= ST_WR_ADDR;
              C_RD:      state_q <= ST_RD_ADDR;
              C_ALU_OP: begin
                state_q  <= ST_ALU_A;
                clk_en_q <= 1'b1;
              end
              C_ALU_NOP: begin
                state_q  <= ST_ALU_FN;
                clk_en_q <= 1'b1;
              end
              default:   cmd_err_q <= 1'b1;
            endcase
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_buf_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q    <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            address_q <= addr_buf_q;
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            address_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_q   <= 1'b1;
            state_q   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (RdData_Valid) begin
            result_q   <= {{DATA_WIDTH{1'b0}}, RdData};
            two_byte_q <= 1'b0;
            state_q    <= ST_TX_LO;
          end else if (timer_expired) begin
            cmd_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_ALU_A: begin
          if (RX_D_VLD) begin
            address_q <= ADDR_WIDTH'(OPA_ADDR);
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= ST_ALU_B;
          end
        end
        ST_ALU_B: begin
          if (RX_D_VLD) begin
            address_q <= ADDR_WIDTH'(OPB_ADDR);
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= ST_ALU_FN;
          end
        end
        ST_ALU_FN: begin
          if (RX_D_VLD) begin
            alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
            alu_en_q  <= 1'b1;
            state_q   <= ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (OUT_Valid) begin
            result_q   <= ALU_OUT;
            two_byte_q <= 1'b1;
            clk_en_q   <= 1'b0;
            state_q    <= ST_TX_LO;
          end else if (timer_expired) begin
            cmd_err_q <= 1'b1;
            clk_en_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        // A push only happens when the FIFO had room; otherwise the byte waits here.
        ST_TX_LO: begin
          if (!FIFO_FULL) begin
            tx_data_q <= result_q[DATA_WIDTH-1:0];
            tx_vld_q  <= 1'b1;
            state_q   <= two_byte_q ? ST_TX_HI : ST_IDLE;
          end
        end
        ST_TX_HI: begin
          if (!FIFO_FULL) begin
            tx_data_q <= result_q[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_vld_q  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Address   = address_q;
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign WrData    = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Frame-level bench: a table of directed frames plus random frames, with
// observed strobes/pushes compared against a transaction-level model.
module tb_rx_cmd_sequencer;

  localparam int TO = 31;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [3:0]  Address;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, cmd_err;
  logic [7:0]  WrData, TX_P_DATA;
  logic [3:0]  ALU_FUN;

  always #5 CLK = ~CLK;

  rx_cmd_sequencer #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .FUN_WIDTH  (4),
    .TIMEOUT    (TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .ALU_OUT      (ALU_OUT),
    .OUT_Valid    (OUT_Valid),
    .FIFO_FULL    (FIFO_FULL),
    .Address      (Address),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .WrData       (WrData),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLK_EN       (CLK_EN),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .cmd_err      (cmd_err)
  );

  typedef struct {
    logic [7:0]  cmd, a, b, fun;
    int          k;       // response delay in wait cycles, -1 = never
    logic [15:0] resp;
    int          full;    // FIFO_FULL cycles after the response pulse
    bit          junk;    // RX pulses alongside/after the response
    int          n_wr;
    logic [11:0] wr0, wr1;
    int          n_rd;
    logic [3:0]  ra;
    int          n_alu;
    logic [3:0]  fn;
    int          n_tx;
    logic [7:0]  t0, t1;
    int          n_err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Monitor: the only writer of these logs.
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];
  bit          txok_q[$];
  bit          ce_q[$];
  int          err_n = 0, cyc = 0, st_cyc = 0, err_cyc = 0;
  bit          prev_full = 1'b0, prev_ce = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (WrEn) wr_q.push_back({Address, WrData});
    if (RdEn) begin rd_q.push_back(Address); st_cyc = cyc; end
    if (ALU_EN) begin alu_q.push_back(ALU_FUN); ce_q.push_back(CLK_EN && prev_ce); st_cyc = cyc; end
    if (TX_D_VLD) begin tx_q.push_back(TX_P_DATA); txok_q.push_back(!prev_full); end
    if (cmd_err) begin err_n++; err_cyc = cyc; end
    prev_full = FIFO_FULL;
    prev_ce   = CLK_EN;
  end

  int b_wr, b_rd, b_alu, b_tx, b_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t predict(vec_t v);
    vec_t e = v;
    bit ok = (v.k >= 0) && (v.k < TO);
    e.n_wr = 0; e.wr0 = '0; e.wr1 = '0; e.n_rd = 0; e.ra = '0; e.n_alu = 0; e.fn = '0;
    e.n_tx = 0; e.t0 = '0; e.t1 = '0; e.n_err = 0;
    case (v.cmd)
      8'hAA: begin e.n_wr = 1; e.wr0 = {v.a[3:0], v.b}; end
      8'hBB: begin
        e.n_rd = 1; e.ra = v.a[3:0];
        if (ok) begin e.n_tx = 1; e.t0 = v.resp[7:0]; end else e.n_err = 1;
      end
      8'hCC, 8'hDD: begin
        if (v.cmd == 8'hCC) begin e.n_wr = 2; e.wr0 = {4'd0, v.a}; e.wr1 = {4'd1, v.b}; end
        e.n_alu = 1; e.fn = v.fun[3:0];
        if (ok) begin e.n_tx = 2; e.t0 = v.resp[7:0]; e.t1 = v.resp[15:8]; end else e.n_err = 1;
      end
      default: e.n_err = 1;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic mark();
    b_wr = wr_q.size(); b_rd = rd_q.size(); b_alu = alu_q.size();
    b_tx = tx_q.size(); b_err = err_n;
  endtask

  task automatic drive(vec_t v);
    send(v.cmd);
    case (v.cmd)
      8'hAA: begin send(v.a); send(v.b); end
      8'hBB: send(v.a);
      8'hCC: begin send(v.a); send(v.b); send(v.fun); end
      8'hDD: send(v.fun);
      default: ;
    endcase
    if ((v.cmd == 8'hBB || v.cmd == 8'hCC || v.cmd == 8'hDD) && v.k >= 0) begin
      repeat (v.k) tick();
      if (v.cmd == 8'hBB) begin RdData = v.resp[7:0]; RdData_Valid = 1'b1; end
      else begin ALU_OUT = v.resp; OUT_Valid = 1'b1; end
      if (v.junk && v.k < TO) begin RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1; end
      tick();
      RdData_Valid = 1'b0;
      OUT_Valid    = 1'b0;
      FIFO_FULL    = (v.full > 0);
      tick();
      RX_D_VLD = 1'b0;
      for (int i = 1; i < v.full; i++) tick();
      FIFO_FULL = 1'b0;
    end
    repeat (TO + 6) tick();
  endtask

  task automatic check_frame(vec_t e, string tag);
    chk({tag, "_nwr"}, wr_q.size() - b_wr, e.n_wr);
    if (e.n_wr > 0 && wr_q.size() > b_wr) chk({tag, "_wr0"}, wr_q[b_wr], e.wr0);
    if (e.n_wr > 1 && wr_q.size() > b_wr + 1) chk({tag, "_wr1"}, wr_q[b_wr+1], e.wr1);
    chk({tag, "_nrd"}, rd_q.size() - b_rd, e.n_rd);
    if (e.n_rd > 0 && rd_q.size() > b_rd) chk({tag, "_rdaddr"}, rd_q[b_rd], e.ra);
    chk({tag, "_nalu"}, alu_q.size() - b_alu, e.n_alu);
    if (e.n_alu > 0 && alu_q.size() > b_alu) begin
      chk({tag, "_alufun"}, alu_q[b_alu], e.fn);
      chk({tag, "_clken_lead"}, ce_q[b_alu], 1);
    end
    chk({tag, "_ntx"}, tx_q.size() - b_tx, e.n_tx);
    if (e.n_tx > 0 && tx_q.size() > b_tx) chk({tag, "_tx0"}, tx_q[b_tx], e.t0);
    if (e.n_tx > 1 && tx_q.size() > b_tx + 1) chk({tag, "_tx1"}, tx_q[b_tx+1], e.t1);
    for (int i = b_tx; i < tx_q.size(); i++) chk({tag, "_push_when_full"}, txok_q[i], 1);
    chk({tag, "_nerr"}, err_n - b_err, e.n_err);
    if (e.n_err > 0 && (e.n_rd + e.n_alu) > 0) chk({tag, "_timeout_lat"}, err_cyc - st_cyc, TO);
    chk({tag, "_clken_idle"}, CLK_EN, 0);
    $display("frame %s cmd=%02h wr=%0d rd=%0d alu=%0d tx=%0d err=%0d", tag, e.cmd,
             wr_q.size() - b_wr, rd_q.size() - b_rd, alu_q.size() - b_alu,
             tx_q.size() - b_tx, err_n - b_err);
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    tbl[0] = '{8'hAA, 8'h05, 8'h3C, 8'h00, -1, 16'h0000, 0, 1'b0, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0};
    tbl[1] = '{8'hBB, 8'h05, 8'h00, 8'h00, 3, 16'h003C, 0, 1'b0, 0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00, 0};
    tbl[2] = '{8'hCC, 8'h07, 8'h03, 8'h00, 2, 16'h000A, 0, 1'b0, 2, 12'h007, 12'h103, 0, 4'h0, 1, 4'h0, 2, 8'h0A, 8'h00, 0};
    tbl[3] = '{8'hDD, 8'h00, 8'h00, 8'h02, 4, 16'h1234, 10, 1'b0, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h2, 2, 8'h34, 8'h12, 0};
    tbl[4] = '{8'h55, 8'h00, 8'h00, 8'h00, -1, 16'h0000, 0, 1'b0, 0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 1};
    tbl[5] = '{8'hBB, 8'h01, 8'h00, 8'h00, -1, 16'h0000, 0, 1'b0, 0, 12'h000, 12'h000, 1, 4'h1, 0, 4'h0, 0, 8'h00, 8'h00, 1};
    tbl[6] = '{8'hAA, 8'h1F, 8'hC3, 8'h00, -1, 16'h0000, 0, 1'b0, 1, 12'hFC3, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0};
    tbl[7] = '{8'hBB, 8'h0A, 8'h00, 8'h00, 30, 16'h0077, 0, 1'b1, 0, 12'h000, 12'h000, 1, 4'hA, 0, 4'h0, 1, 8'h77, 8'h00, 0};
    tbl[8] = '{8'hDD, 8'h00, 8'h00, 8'h1B, 31, 16'hBEEF, 0, 1'b0, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'hB, 0, 8'h00, 8'h00, 1};
    tbl[9] = '{8'hCC, 8'hFF, 8'h80, 8'h3F, 0, 16'hFE01, 3, 1'b1, 2, 12'h0FF, 12'h180, 0, 4'h0, 1, 4'hF, 2, 8'h01, 8'hFE, 0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", {Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD, cmd_err}, 0);
    $display("reset outputs checked");
    tick();
    RST = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      mark();
      drive(tbl[i]);
      check_frame(tbl[i], $sformatf("row%0d", i));
    end

    // Reset between the write command and its data byte: nothing is written,
    // and the following byte is decoded as a (bad) command from IDLE.
    mark();
    send(8'hAA);
    send(8'h05);
    RST = 1'b0;
    #3;
    chk("midreset_outputs", {Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD, cmd_err}, 0);
    tick();
    RST = 1'b1;
    tick();
    send(8'h3C);
    repeat (8) tick();
    chk("midreset_nwr", wr_q.size() - b_wr, 0);
    chk("midreset_nerr", err_n - b_err, 1);
    chk("midreset_ntx", tx_q.size() - b_tx, 0);
    $display("frame midreset wr=%0d err=%0d", wr_q.size() - b_wr, err_n - b_err);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: v.cmd = 8'hAA;
        1: v.cmd = 8'hBB;
        2: v.cmd = 8'hCC;
        3: v.cmd = 8'hDD;
        default: v.cmd = 8'($urandom);
      endcase
      v.a    = 8'($urandom);
      v.b    = 8'($urandom);
      v.fun  = 8'($urandom);
      v.k    = int'($urandom_range(0, TO + 3)) - 1;
      v.resp = 16'($urandom);
      v.full = int'($urandom_range(0, 6));
      v.junk = 1'($urandom);
      v = predict(v);
      mark();
      drive(v);
      check_frame(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
